// File: rtl/sr04_dist_filter_if.sv
// Signal bundle between the HC-SR04 controller side and the distance filter.
// Defining SR04_FILT_REJECT_CNT_EN adds the rejected-sample counter output.
interface sr04_dist_filter_if;
  logic       iTickUs;
  logic [9:0] iDistanceCm;
  logic       iDistanceValid;
  logic [9:0] oAvgCm;
  logic       oAvgValid;
  logic [11:0] oBcd;
  logic       oBcdValid;
  logic       oStale;
`ifdef SR04_FILT_REJECT_CNT_EN
  logic [7:0] oRejectCnt;

  modport master (
    output iTickUs, iDistanceCm, iDistanceValid,
    input  oAvgCm, oAvgValid, oBcd, oBcdValid, oStale, oRejectCnt
  );
  modport slave (
    input  iTickUs, iDistanceCm, iDistanceValid,
    output oAvgCm, oAvgValid, oBcd, oBcdValid, oStale, oRejectCnt
  );
`else
  modport master (
    output iTickUs, iDistanceCm, iDistanceValid,
    input  oAvgCm, oAvgValid, oBcd, oBcdValid, oStale
  );
  modport slave (
    input  iTickUs, iDistanceCm, iDistanceValid,
    output oAvgCm, oAvgValid, oBcd, oBcdValid, oStale
  );
`endif
endinterface

// File: rtl/sr04_dist_filter.sv
// Range-checks HC-SR04 distances, keeps a power-of-two moving average, converts it to BCD
// and flags staleness. Optional rejected-sample counter: define SR04_FILT_REJECT_CNT_EN.
module sr04_dist_filter #(
  parameter int WIN_LOG2         = 2,
  parameter int MAX_VALID_CM     = 400,
  parameter int STALE_TIMEOUT_US = 200_000
) (
  input logic               iClk,
  input logic               iRstn,
  sr04_dist_filter_if.slave bus
);
  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = 10 + WIN_LOG2;
  localparam int CNT_W = $clog2(STALE_TIMEOUT_US + 1);
  localparam logic [9:0]       MAX_CM    = 10'(MAX_VALID_CM);
  localparam logic [CNT_W-1:0] STALE_LIM = CNT_W'(STALE_TIMEOUT_US);
  localparam logic [CNT_W-1:0] STALE_PRE = CNT_W'(STALE_TIMEOUT_US - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [9:0] win_avg(input logic [SUM_W-1:0] s);
    return 10'(s >> WIN_LOG2);
  endfunction

  // One double-dabble iteration over {bcd[11:0], bin[9:0]}.
  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[10+4*k +: 4] >= 4'd5) t[10+4*k +: 4] = t[10+4*k +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  logic                vld_prev;
  logic                strobe;
  logic                accept;
  logic                timeout_hit;
  logic [9:0]          win_buf [DEPTH];
  logic [SUM_W-1:0]    sum_p0;
  logic [WIN_LOG2-1:0] wp;
  logic                primed;
  logic                vld_p0;
  logic [CNT_W-1:0]    stale_cnt;

  logic [9:0]          avg_p1;
  logic                vld_p1;
  logic                stale_p1;
  logic                pending;

  state_t              state, state_nx;
  logic [3:0]          bit_cnt;
  logic [21:0]         shreg;
  logic [11:0]         bcd_p2;
  logic                vld_p2;

  assign strobe      = bus.iDistanceValid & ~vld_prev;
  assign accept      = strobe && (bus.iDistanceCm != 10'd0) && (bus.iDistanceCm <= MAX_CM);
  assign timeout_hit = !accept && bus.iTickUs && (stale_cnt == STALE_PRE);

  // Stage p0: sample strobe, window buffer, running sum, stale timer
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      vld_prev  <= 1'b0;
      vld_p0    <= 1'b0;
      sum_p0    <= '0;
      wp        <= '0;
      primed    <= 1'b0;
      stale_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) win_buf[i] <= '0;
    end else begin
      vld_prev <= bus.iDistanceValid;
      vld_p0   <= accept;
      if (accept) begin
        stale_cnt <= '0;
        primed    <= 1'b1;
        if (!primed) begin
          for (int i = 0; i < DEPTH; i++) win_buf[i] <= bus.iDistanceCm;
          sum_p0 <= SUM_W'(bus.iDistanceCm) << WIN_LOG2;
          wp     <= WIN_LOG2'(1);
        end else begin
          sum_p0      <= sum_p0 - SUM_W'(win_buf[wp]) + SUM_W'(bus.iDistanceCm);
          win_buf[wp] <= bus.iDistanceCm;
          wp          <= wp + WIN_LOG2'(1);
        end
      end else if (bus.iTickUs && stale_cnt != STALE_LIM) begin
        stale_cnt <= stale_cnt + CNT_W'(1);
        if (timeout_hit) primed <= 1'b0;
      end
    end
  end

  // Stage p1: published average, validity and staleness
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      avg_p1   <= '0;
      vld_p1   <= 1'b0;
      stale_p1 <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (vld_p0) begin
        avg_p1   <= win_avg(sum_p0);
        vld_p1   <= 1'b1;
        stale_p1 <= 1'b0;
      end else if (timeout_hit) begin
        vld_p1   <= 1'b0;
        stale_p1 <= 1'b1;
      end
      // A fresh average must survive a load of the previous one on the same edge.
      if (vld_p0)              pending <= 1'b1;
      else if (state == IDLE)  pending <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pending) state_nx = SHIFT;
      SHIFT:   if (bit_cnt == 4'd9) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p2: bit-serial binary-to-BCD conversion
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      bit_cnt <= '0;
      shreg   <= '0;
      bcd_p2  <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= (state == DONE);
      case (state)
        IDLE: if (pending) begin
          shreg   <= {12'd0, avg_p1};
          bit_cnt <= '0;
        end
        SHIFT: begin
          shreg   <= dabble_step(shreg);
          bit_cnt <= bit_cnt + 4'd1;
        end
        DONE:    bcd_p2 <= shreg[21:10];
        default: ;
      endcase
    end
  end

`ifdef SR04_FILT_REJECT_CNT_EN
  logic [7:0] rej_cnt;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn)                                       rej_cnt <= '0;
    else if (strobe && !accept && rej_cnt != 8'hFF)   rej_cnt <= rej_cnt + 8'd1;
  end

  assign bus.oRejectCnt = rej_cnt;
`endif

  assign bus.oAvgCm    = avg_p1;
  assign bus.oAvgValid = vld_p1;
  assign bus.oStale    = stale_p1;
  assign bus.oBcd      = bcd_p2;
  assign bus.oBcdValid = vld_p2;

endmodule

// File: doc/sr04_dist_filter.md
Name: sr04_dist_filter

Overview:
Downstream consumer of the HC-SR04 controller. It takes each completed distance measurement, rejects out-of-range samples, and keeps a power-of-two moving average of accepted samples. It converts the average to 3-digit BCD for the FND display path, and flags the output stale when no good sample has arrived for a set time.

Parameters:
WIN_LOG2, 2, log2 of window depth (depth = 2^WIN_LOG2; legal 1..4)
MAX_VALID_CM, 400, largest accepted sample in cm; must be <= 999
STALE_TIMEOUT_US, 200_000, iTickUs count without an accepted sample before oStale asserts

Ports:
iClk  in  1  system clock
iRstn  in  1  asynchronous active-low reset
iTickUs  in  1  1-cycle pulse every 1 us
iDistanceCm  in  10  distance from controller, cm
iDistanceValid  in  1  controller valid level; held high until the next trigger
oAvgCm  out  10  windowed average, cm
oAvgValid  out  1  level; average reflects a primed window and is not stale
oBcd  out  12  {hundreds,tens,ones} BCD of oAvgCm
oBcdValid  out  1  1-cycle pulse when oBcd updates
oStale  out  1  level; timeout since last accepted sample

Behaviour:
- Reset (iRstn low, async): all outputs 0; buffer, sum, pointer, stale counter 0; window empty; BCD FSM IDLE; pending flag 0; valid-edge register 0.
- Sample strobe = rising edge of iDistanceValid (registered previous value). A level held high produces exactly one strobe.
- Accept when 1 <= iDistanceCm <= MAX_VALID_CM; otherwise reject. A rejected sample changes no state and does not restart the stale timer.
- Window empty + accept (priming): every entry = sample, sum = sample << WIN_LOG2, write pointer = 1 (mod depth).
- Window primed + accept: sum <= sum - buf[wp] + sample; buf[wp] <= sample; wp increments and wraps at depth. Sum width 10+WIN_LOG2; no overflow possible.
- Latency: strobe detected at edge N updates buffer/sum at N. At N+1: oAvgCm = sum >> WIN_LOG2 (truncating), oAvgValid = 1, oStale = 0, BCD pending flag set.
- Stale counter: cleared on accept; increments on iTickUs, saturating at STALE_TIMEOUT_US. On reaching STALE_TIMEOUT_US: oStale = 1, oAvgValid = 0, window marked empty; oAvgCm and oBcd retain their values.
- Accept and timeout on the same cycle: accept wins; counter cleared, oStale stays 0.
- BCD FSM (double-dabble, one bit per cycle):
  - IDLE: if pending, load the shift register from oAvgCm, clear pending, go to SHIFT.
  - SHIFT: for each of 10 iterations, add 3 to any BCD nibble >= 5, then shift left 1. After the 10th iteration go to DONE.
  - DONE: write oBcd, pulse oBcdValid for 1 cycle, return to IDLE.
  - Load at N+2; oBcd and oBcdValid appear at N+13, i.e. 12 cycles after oAvgCm.
- A new average arriving during SHIFT/DONE only sets pending. The running conversion completes, then one more conversion starts from the current oAvgCm. Multiple arrivals collapse to a single pending conversion.
- Reset mid-operation aborts the conversion; no oBcdValid pulse.

Optional Feature:
SR04_FILT_REJECT_CNT_EN
- Defined: adds output oRejectCnt[7:0]. It increments on each rejected strobe, saturates at 255, clears only on reset, and is 0 after reset.
- Undefined: the port and counter are absent; reject behaviour is otherwise identical.

Test Plan:
- Prime and average (WIN_LOG2=2): strobes with 100, 104, 108, 112 -> oAvgCm 100, 101, 103, 106, each 1 cycle after its strobe; final oBcd=12'h106 with one oBcdValid pulse 12 cycles after oAvgCm updates.
- Reject: after prime at 100, strobes with 0 and 450 -> oAvgCm stays 100, no oBcdValid pulse, stale counter not cleared; with the macro defined, oRejectCnt=2.
- Stale (STALE_TIMEOUT_US=1000): no accept for 1000 ticks -> oStale=1, oAvgValid=0, oAvgCm held; next strobe 50 -> oAvgCm=50 (re-primed), oStale=0, oBcd=12'h050.
- Level hold: iDistanceValid held high 500 cycles with 77 -> exactly one accept, one oBcdValid pulse, oBcd=12'h077.
- Back-to-back: second strobe 3 cycles after the first (primed at 200, then 204) -> two oBcdValid pulses; last oBcd=12'h201.
- Reset during SHIFT: iRstn low 2 cycles -> all outputs 0 immediately; FSM IDLE; no oBcdValid pulse afterwards.
